multicycle_alu: RTL



---
 rtl/alu_op_pkg.sv | 31 +++
 rtl/alu_logic_unit.sv | 27 ++
 rtl/multicycle_alu.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_op_pkg.sv
// Op codes, FSM state encoding and width defaults shared by the ALU control
// decoder and the multicycle ALU.
package alu_op_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_NOR     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_LUI     = 4'b0101;
  localparam logic [3:0] OP_SLL     = 4'b0110;
  localparam logic [3:0] OP_SRL     = 4'b0111;
  localparam logic [3:0] OP_ILLEGAL = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_SRL);
  endfunction

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational single-cycle ALU ops: AND/OR/NOR/ADD/SUB/LUI.
module alu_logic_unit
  import alu_op_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_NOR: y = ~(a | b);
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      // Low halfword of the immediate moves into the upper half, zero below.
      OP_LUI: y = b << 16;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ALU: logic/arith/LUI finish in one cycle, SLL/SRL shift one
// bit per cycle counted down from shamt.
module multicycle_alu
  import alu_op_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   illegal_op
);

  state_t                  state, state_nx;
  logic [DATA_WIDTH-1:0]   sh_q, sh_nx, unit_y, res_nx;
  logic [SHAMT_WIDTH-1:0]  cnt_q;
  logic                    left_q, ill_q, ill_nx;
  logic                    accept, load_res, op_legal, op_shift;

  alu_logic_unit #(.DATA_WIDTH(DATA_WIDTH)) u_logic (
    .op (ALUOperation),
    .a  (A),
    .b  (B),
    .y  (unit_y)
  );

  always_comb begin
    op_legal = op_is_legal(ALUOperation);
    op_shift = op_is_shift(ALUOperation);
    accept   = start && (state != ST_SHIFT);
    sh_nx    = left_q ? (sh_q << 1) : (sh_q >> 1);
    res_nx   = unit_y;
    ill_nx   = 1'b0;
    if (state == ST_SHIFT) begin
      res_nx = sh_nx;
    end else if (!op_legal) begin
      res_nx = '0;
      ill_nx = 1'b1;
    end else if (op_shift) begin
      res_nx = B;  // shamt == 0 degenerates to a pass-through
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    load_res = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done     = (state == ST_DONE);
        state_nx = ST_IDLE;
        if (accept) begin
          if (op_shift && (shamt != '0)) begin
            state_nx = ST_SHIFT;
          end else begin
            state_nx = ST_DONE;
            load_res = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          state_nx = ST_DONE;
          load_res = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      ill_q     <= 1'b0;
    end else begin
      if (accept) begin
        sh_q   <= B;
        cnt_q  <= shamt;
        left_q <= (ALUOperation == OP_SLL);
      end else if (state == ST_SHIFT) begin
        sh_q  <= sh_nx;
        cnt_q <= cnt_q - SHAMT_WIDTH'(1);
      end
      if (load_res) begin
        ALUResult <= res_nx;
        Zero      <= (res_nx == '0);
        ill_q     <= ill_nx;
      end
    end
  end

  // The flag is held with the result but only shown during the done pulse.
  assign illegal_op = ill_q && done;

endmodule
